// File: rtl/tone_player_pkg.sv
// Shared types and note tables for the buzzer tone player.
// Frequencies are base octave 3, in milli-Hz.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned REST    = 0;
  localparam int unsigned NOTE_C  = 1;
  localparam int unsigned NOTE_CS = 2;
  localparam int unsigned NOTE_D  = 3;
  localparam int unsigned NOTE_DS = 4;
  localparam int unsigned NOTE_E  = 5;
  localparam int unsigned NOTE_F  = 6;
  localparam int unsigned NOTE_FS = 7;
  localparam int unsigned NOTE_G  = 8;
  localparam int unsigned NOTE_GS = 9;
  localparam int unsigned NOTE_A  = 10;
  localparam int unsigned NOTE_AS = 11;
  localparam int unsigned NOTE_B  = 12;

  localparam int unsigned FREQ_MHZ [12] = '{
    130813, 138591, 146832, 155563,
    164814, 174614, 184997, 195998,
    207652, 220000, 233082, 246942
  };

  // Half period in clock cycles; 0 marks a rest code.
  function automatic int unsigned half_period(
    input longint unsigned clk_hz,
    input int unsigned     note
  );
    longint unsigned q;
    if (note < NOTE_C || note > NOTE_B) return 0;
    q = (clk_hz * 1000) /
        (2 * longint'(FREQ_MHZ[note-1]));
    return 32'(q);
  endfunction

endpackage

// File: rtl/tone_player_if.sv
// Note-event valid/ready channel into the tone player.
// Master is the sequencer, slave is the player.
interface tone_player_if #(
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned OCT_W  = 2,
  parameter int unsigned DUR_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [NOTE_W-1:0] in_note;
  logic [OCT_W-1:0]  in_oct;
  logic [DUR_W-1:0]  in_dur;

  modport master (
    output in_valid, in_note, in_oct, in_dur,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_note, in_oct, in_dur,
    output in_ready
  );
endinterface

// File: rtl/tone_player_divider.sv
// Square-wave generator: toggles every i_half cycles.
// Held cleared (tone low, phase 0) while i_clr is high.
module tone_divider
  import buzzer_pkg::*;
#(
  parameter int unsigned PH_W = 12
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [PH_W-1:0] i_half,
  output logic            o_tone
);

  logic [PH_W-1:0] r_cnt;
  logic [PH_W-1:0] w_lim;

  // A zero half period toggles every cycle instead of underflowing.
  assign w_lim = (i_half == '0) ? '0 : i_half - 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt  <= '0;
      o_tone <= 1'b0;
    end else if (i_en) begin
      if (r_cnt >= w_lim) begin
        r_cnt  <= '0;
        o_tone <= ~o_tone;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_player.sv
// Single-voice note player driving the buzzer pin.
// TONE_PLAYER_VOLUME_EN adds i_vol and a 4-cycle PWM carrier.
module tone_player
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned NOTE_W    = 4,
  parameter int unsigned OCT_W     = 2,
  parameter int unsigned DUR_W     = 8,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  tone_player_if.slave      s_in,
  input  logic              i_stop,
`ifdef TONE_PLAYER_VOLUME_EN
  input  logic [1:0]        i_vol,
`endif
  output logic              o_buzz,
  output logic              o_busy,
  output logic [NOTE_W-1:0] o_cur_note,
  output logic              o_done
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HMAX = half_period(CLK_HZ, NOTE_C);
  localparam int unsigned PH_W = $clog2(HMAX + 1);
  localparam int unsigned GW   = $clog2(GAP_TICKS + 1);
  localparam int unsigned CW   = (DUR_W > GW) ? DUR_W : GW;

  state_t            r_state;
  logic [NOTE_W-1:0] r_note;
  logic [OCT_W-1:0]  r_oct;
  logic [DUR_W-1:0]  r_dur;
  logic [PS_W-1:0]   r_ps;
  logic [CW-1:0]     r_tcnt;

  logic              w_accept;
  logic              w_tick;
  logic [CW-1:0]     w_tnext;
  logic              w_play_end;
  logic              w_gap_end;
  logic [PH_W-1:0]   w_tab [2**NOTE_W];
  logic [PH_W-1:0]   w_half;
  logic              w_is_tone;
  logic              w_tone;
  logic              w_pwm;

  // Elaboration-time half-period table, one entry per note code.
  for (genvar g = 0; g < 2**NOTE_W; g++) begin : g_tab
    assign w_tab[g] = PH_W'(half_period(CLK_HZ, g));
  end

  assign w_half     = w_tab[r_note] >> r_oct;
  assign w_is_tone  = |w_tab[r_note];
  assign w_accept   = s_in.in_valid && s_in.in_ready;
  assign w_tick     = (r_ps == PS_W'(DIV - 1));
  assign w_tnext    = r_tcnt + CW'(1);
  assign w_play_end = w_tick && (w_tnext == CW'(r_dur));
  assign w_gap_end  = w_tick && (w_tnext == CW'(GAP_TICKS));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_note  <= '0;
      r_oct   <= '0;
      r_dur   <= '0;
      r_ps    <= '0;
      r_tcnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_note  <= s_in.in_note;
            r_oct   <= s_in.in_oct;
            r_dur   <= s_in.in_dur;
            r_ps    <= '0;
            r_tcnt  <= '0;
            r_state <= (s_in.in_dur == '0) ? GAP : PLAY;
          end
        end
        PLAY: begin
          if (i_stop) begin
            r_state <= IDLE;
          end else begin
            r_ps <= w_tick ? '0 : r_ps + 1'b1;
            if (w_play_end) begin
              r_state <= GAP;
              r_tcnt  <= '0;
            end else if (w_tick) begin
              r_tcnt <= w_tnext;
            end
          end
        end
        GAP: begin
          if (i_stop) begin
            r_state <= IDLE;
          end else begin
            r_ps <= w_tick ? '0 : r_ps + 1'b1;
            if (w_gap_end) begin
              r_state <= IDLE;
              r_tcnt  <= '0;
            end else if (w_tick) begin
              r_tcnt <= w_tnext;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  tone_divider #(
    .PH_W (PH_W)
  ) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (r_state != PLAY),
    .i_en   ((r_state == PLAY) && w_is_tone),
    .i_half (w_half),
    .o_tone (w_tone)
  );

`ifdef TONE_PLAYER_VOLUME_EN
  logic [1:0] r_vol;
  logic [1:0] r_pwm;

  // Carrier phase restarts at accept so the duty is aligned to the note.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vol <= '0;
      r_pwm <= '0;
    end else if (w_accept) begin
      r_vol <= i_vol;
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  assign w_pwm = (r_pwm <= r_vol);
`else
  assign w_pwm = 1'b1;
`endif

  assign s_in.in_ready = (r_state == IDLE) && !i_stop;
  assign o_busy        = (r_state != IDLE);
  assign o_cur_note    = (r_state == PLAY) ? r_note : '0;
  assign o_buzz        = w_tone && w_pwm && (r_state == PLAY);
  assign o_done        = (r_state == GAP) && w_gap_end && !i_stop;

endmodule

// File: doc/tone_player.md
# tone_player

Parametrised single-voice note player for the piano's buzzer output. It accepts note events over a valid/ready handshake, where each event carries a note, an octave and a duration. Each note is played as a square wave for the requested number of ticks, followed by a fixed silent gap, after which the block returns to idle. It sits between the keyboard/song sequencer and the buzzer pin, and replaces the fixed 4-bit free-running buzzer.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1000, duration tick rate (default 1 tick = 1 ms)
- NOTE_W, 4, note code width; 0 = rest, 1..12 = C..B, 13..max = rest
- OCT_W, 2, octave select width; octave o plays base octave 3 + o
- DUR_W, 8, duration width in ticks
- GAP_TICKS, 10, silent ticks after every note
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  note event offered
- in_ready  out  1  block accepts the event this cycle
- in_note  in  NOTE_W  note code
- in_oct  in  OCT_W  octave
- in_dur  in  DUR_W  duration in ticks
- stop  in  1  abort the current note/gap
- buzz  out  1  square-wave buzzer drive
- busy  out  1  high in PLAY or GAP
- cur_note  out  NOTE_W  note being played; 0 when not in PLAY
- done  out  1  one-cycle pulse when GAP completes

## Operation
- States: IDLE, PLAY, GAP. Reset → IDLE. All outputs are 0 after reset except in_ready, which is 1 (stop low).
- in_ready = (state==IDLE) && !stop. Accept = in_valid && in_ready.
- IDLE + accept:
  - Latch note, octave and duration.
  - Clear the tick prescaler, tick counter and phase counter; buzz goes 0.
  - Next state is PLAY, or GAP if in_dur==0.
- PLAY, tone note (1..12):
  - buzz toggles each time the phase counter reaches HALF[note]>>oct minus 1; the counter then returns to 0.
  - HALF[n] = CLK_HZ / (2·f(n, octave 3)), rounded down.
- PLAY, rest code: buzz holds 0 and timing is identical to a tone note.
- Ticks:
  - The prescaler wraps every CLK_HZ/TICK_HZ cycles and produces a tick.
  - PLAY → GAP on the tick that makes the tick count equal the latched duration.
  - On the PLAY → GAP transition, buzz is forced 0 and the tick counter is cleared.
- GAP → IDLE on the GAP_TICKS-th tick, with done=1 in that same cycle.
- stop in PLAY or GAP → IDLE next cycle, buzz=0, no done pulse. stop in IDLE blocks acceptance.
- Widths:
  - The phase counter is sized by clog2 of the largest HALF value (C3).
  - Octave shift is a right shift with no rounding.
  - The duration counter is DUR_W bits and never wraps, because it stops at the latched duration.

## Timing
- Accept in cycle t:
  - busy=1 and cur_note is valid from t+1.
  - The first buzz rising edge is at t+1+HALF>>oct.
- A note of D ticks lasts exactly D·CLK_HZ/TICK_HZ cycles of PLAY.
- The gap lasts exactly GAP_TICKS·CLK_HZ/TICK_HZ cycles.
- done is asserted in the last GAP cycle. in_ready rises in the next cycle, so back-to-back notes are separated by at least one IDLE cycle.
- rst overrides stop and accept. Reset mid-note → IDLE next cycle and buzz=0.

## Configuration
- TONE_PLAYER_VOLUME_EN defined:
  - Adds port vol (in, 2 bits), latched at accept.
  - buzz = tone && pwm, where pwm is a 4-cycle carrier that is high for vol+1 of every 4 cycles.
  - vol=3 gives the full square wave.
- Undefined: the vol port is absent and buzz is the plain square wave.

## Structure
- Package buzzer_pkg holds:
  - the state enum,
  - the 12-entry base-octave frequency table (milli-Hz),
  - function half_period(clk_hz, note),
  - the note code constants (REST = 0).
- Sub-module tone_divider generates the square wave: phase counter, toggle, clear.

## Test plan
All scenarios use CLK_HZ=1_000_000, TICK_HZ=1000, GAP_TICKS=2.
- Reset:
  - Stimulus: rst held 3 cycles.
  - Response: buzz=0, busy=0, done=0, cur_note=0, in_ready=1.
- Single A4 note:
  - Stimulus: note 10, oct 1, dur 3.
  - Response: buzz period 2·(2272>>1)=2272 cycles; PLAY 3000 cycles; GAP 2000 cycles; one done pulse; in_ready returns one cycle later.
- Rest and zero duration:
  - Stimulus: note 0, dur 2; then note 13, dur 2; then note 5, dur 0.
  - Response: buzz stays 0 throughout; the dur-0 event goes straight to GAP (2000 cycles).
- Stop:
  - Stimulus: stop asserted mid-PLAY; then stop and in_valid together in IDLE.
  - Response: IDLE next cycle with buzz=0 and no done; no acceptance while stop is high.
- Back-to-back:
  - Stimulus: in_valid held high with two queued events.
  - Response: the second is accepted exactly one cycle after done, with no overlap of busy.
- Volume (TONE_PLAYER_VOLUME_EN):
  - Stimulus: vol=0 on a tone note.
  - Response: buzz high for 1 of 4 cycles during tone-high phases.
